axi_slave_ram_rw: RTL and testbench

- Parametrised AXI4 memory slave with full read (AR/R) and write (AW/W/B) channels over a single-port-per-direction word RAM.
- Supports FIXED, INCR and WRAP bursts, configurable depth and data width, and SLVERR signalling for illegal accesses.
- Next generation of the read-only burst RAM slave; sits behind the interconnect as a scratch memory and as a bench target for AXI masters.

---
 rtl/axi_ram_pkg.sv | 54 +++++
 rtl/axi_burst_addr_gen.sv | 81 ++++++++
 rtl/axi_slave_ram_rw.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_slave_ram_rw.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_pkg.sv
// Shared encodings, FSM state types and burst address arithmetic for the
// AXI RAM slave and its burst address generators.
package axi_ram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Byte address of the beat following addr; callers truncate to their width.
    // WRAP with an unsupported length falls back to INCR.
    function automatic logic [31:0] next_addr(
        input logic [31:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [31:0] incr;
        logic [31:0] wrap_mask;
        logic [31:0] nxt;
        incr      = 32'd1 << size;
        nxt       = addr + incr;
        wrap_mask = ((32'(len) + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP: begin
                if (wrap_len_ok(len))
                    next_addr = (addr & ~wrap_mask) | (nxt & wrap_mask);
                else
                    next_addr = nxt;
            end
            default: next_addr = nxt;
        endcase
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst address and beat counter. Outputs show the beat that is current once
// this cycle's start/advance has taken effect, so callers can register data for it.
module axi_burst_addr_gen
    import axi_ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 64
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] start_addr,
    input  logic [7:0]               start_len,
    input  logic [2:0]               start_size,
    input  logic [1:0]               start_burst,
    input  logic                     advance,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic                     last,
    output logic                     err
);

    localparam int WSHIFT = $clog2(DATA_WIDTH / 8);

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [ADDRESS_WIDTH-1:0] addr_nx;
    logic [ADDRESS_WIDTH-1:0] cur_addr;
    logic [ADDRESS_WIDTH-1:0] widx;
    logic [7:0]               cnt_q;
    logic [7:0]               cur_cnt;
    logic [7:0]               len_q;
    logic [2:0]               size_q;
    logic [1:0]               burst_q;
    logic                     berr_q;
    logic                     cur_berr;
    logic                     step;

    // cnt_q counts remaining beats down to the terminal value 0.
    assign step    = advance && (cnt_q != 8'd0);
    assign addr_nx = ADDRESS_WIDTH'(next_addr(32'(addr_q), len_q, size_q, burst_q));

    always_comb begin
        cur_addr = addr_q;
        cur_cnt  = cnt_q;
        cur_berr = berr_q;
        if (start) begin
            cur_addr = start_addr;
            cur_cnt  = start_len;
            cur_berr = (start_size != 3'(WSHIFT)) || (start_burst == BURST_RSVD);
        end else if (step) begin
            cur_addr = addr_nx;
            cur_cnt  = cnt_q - 8'd1;
        end
    end

    assign widx = cur_addr >> WSHIFT;
    assign addr = cur_addr;
    assign last = (cur_cnt == 8'd0);
    assign err  = cur_berr || (32'(widx) >= 32'(DEPTH));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            berr_q  <= 1'b0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
        end else begin
            addr_q <= cur_addr;
            cnt_q  <= cur_cnt;
            berr_q <= cur_berr;
            if (start) begin
                len_q   <= start_len;
                size_q  <= start_size;
                burst_q <= start_burst;
            end
        end
    end

endmodule

// File: rtl/axi_slave_ram_rw.sv
// AXI4 read/write burst RAM slave with independent read and write FSMs.
// Define AXI_RAM_WSTRB_EN to add the wstrb port and byte-masked writes.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read burst
// R_DATA | presenting read beats until the rlast handshake
// W_IDLE | awready high, waiting for a write burst
// W_DATA | wready high, accepting awlen+1 write beats
// W_RESP | bvalid high until bready
module axi_slave_ram_rw
    import axi_ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 64
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [ADDRESS_WIDTH-1:0]  araddr,
    input  logic [7:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready,
    input  logic [ADDRESS_WIDTH-1:0]  awaddr,
    input  logic [7:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
`ifdef AXI_RAM_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
`endif
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready
);

    localparam int STRB   = DATA_WIDTH / 8;
    localparam int WSHIFT = $clog2(STRB);
    localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    rd_state_t                rd_state;
    wr_state_t                wr_state;
    logic                     ar_fire;
    logic                     rd_fire;
    logic                     rd_adv;
    logic                     aw_fire;
    logic                     w_fire;
    logic                     wadv_q;
    logic                     werr;
    logic                     beat_bad;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] rg_addr;
    logic                     rg_last;
    logic                     rg_err;
    logic [ADDRESS_WIDTH-1:0] wg_addr;
    logic                     wg_last;
    logic                     wg_err;
    logic [IDXW-1:0]          rd_idx;
    logic [IDXW-1:0]          wr_idx;

    assign ar_fire = arvalid && arready;
    assign rd_fire = rvalid && rready;
    assign rd_adv  = rd_fire && !rlast;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;

    axi_burst_addr_gen #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .DEPTH         (DEPTH)
    ) u_rd_gen (
        .aclk        (aclk),
        .areset      (areset),
        .start       (ar_fire),
        .start_addr  (araddr),
        .start_len   (arlen),
        .start_size  (arsize),
        .start_burst (arburst),
        .advance     (rd_adv),
        .addr        (rg_addr),
        .last        (rg_last),
        .err         (rg_err)
    );

    // The write side advances the cycle after a beat is taken, so the
    // generator output always names the beat that wready is offering.
    axi_burst_addr_gen #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .DEPTH         (DEPTH)
    ) u_wr_gen (
        .aclk        (aclk),
        .areset      (areset),
        .start       (aw_fire),
        .start_addr  (awaddr),
        .start_len   (awlen),
        .start_size  (awsize),
        .start_burst (awburst),
        .advance     (wadv_q),
        .addr        (wg_addr),
        .last        (wg_last),
        .err         (wg_err)
    );

    assign rd_idx   = IDXW'(rg_addr >> WSHIFT);
    assign wr_idx   = IDXW'(wg_addr >> WSHIFT);
    assign mem_we   = w_fire && !wg_err;
    assign beat_bad = wg_err || (wlast != wg_last);

    always_ff @(posedge aclk) begin
        if (mem_we) begin
`ifdef AXI_RAM_WSTRB_EN
            for (int i = 0; i < STRB; i++)
                if (wstrb[i])
                    mem[wr_idx][i*8 +: 8] <= wdata[i*8 +: 8];
`else
            mem[wr_idx] <= wdata;
`endif
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state <= R_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
            rlast    <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (ar_fire) begin
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        rdata    <= rg_err ? '0 : mem[rd_idx];
                        rresp    <= rg_err ? RESP_SLVERR : RESP_OKAY;
                        rlast    <= rg_last;
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rd_fire) begin
                        if (rlast) begin
                            rvalid   <= 1'b0;
                            rdata    <= '0;
                            rresp    <= RESP_OKAY;
                            rlast    <= 1'b0;
                            arready  <= 1'b1;
                            rd_state <= R_IDLE;
                        end else begin
                            rdata <= rg_err ? '0 : mem[rd_idx];
                            rresp <= rg_err ? RESP_SLVERR : RESP_OKAY;
                            rlast <= rg_last;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            werr     <= 1'b0;
            wadv_q   <= 1'b0;
        end else begin
            wadv_q <= w_fire;
            case (wr_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (aw_fire) begin
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        werr     <= 1'b0;
                        wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (beat_bad)
                            werr <= 1'b1;
                        if (wg_last) begin
                            wready   <= 1'b0;
                            bvalid   <= 1'b1;
                            bresp    <= (werr || beat_bad) ? RESP_SLVERR : RESP_OKAY;
                            wr_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        bresp    <= RESP_OKAY;
                        awready  <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: begin
                    wr_state <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_ram_rw.sv
// Directed bench for axi_slave_ram_rw: write bursts fill known words, then a
// table of read bursts is checked beat by beat, followed by stall and reset cases.
module tb_axi_slave_ram_rw;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int NRV   = 14;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [AW-1:0] araddr, awaddr;
    logic [7:0]    arlen, awlen;
    logic [2:0]    arsize, awsize;
    logic [1:0]    arburst, awburst;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [DW-1:0] rdata, wdata;
    logic [1:0]    rresp, bresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
`ifdef AXI_RAM_WSTRB_EN
    logic [DW/8-1:0] wstrb = '1;
`endif

    always #5 aclk = ~aclk;

    axi_slave_ram_rw #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awburst (awburst),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
`ifdef AXI_RAM_WSTRB_EN
        .wstrb   (wstrb),
`endif
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0][31:0] d;
        logic [3:0][1:0]  r;
    } rvec_t;

    rvec_t rv [NRV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_rv(input int i, input logic [AW-1:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input logic [1:0] r0, input logic [1:0] r1,
                          input logic [1:0] r2, input logic [1:0] r3);
        rv[i].addr  = a;
        rv[i].len   = len;
        rv[i].size  = sz;
        rv[i].burst = bu;
        rv[i].d     = {d3, d2, d1, d0};
        rv[i].r     = {r3, r2, r1, r0};
    endtask

    task automatic do_write(input string nm, input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu,
                            input logic [31:0] d0, input logic [31:0] step,
                            input int wlast_beat, input logic [1:0] exp_b);
        int g;
        awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
        g = 0;
        while (!awready && g < 20) begin @(posedge aclk); #1; g++; end
        chk({nm, "_awready"}, 32'(awready), 32'd1);
        if (!awready) begin awvalid = 1'b0; return; end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wdata  = d0 + 32'(i) * step;
            wlast  = (i == wlast_beat);
            g = 0;
            while (!wready && g < 20) begin @(posedge aclk); #1; g++; end
            if (!wready) begin
                chk($sformatf("%s_wready_b%0d", nm, i), 32'(wready), 32'd1);
                break;
            end
            @(posedge aclk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        g = 0;
        while (!bvalid && g < 20) begin @(posedge aclk); #1; g++; end
        chk({nm, "_bvalid"}, 32'(bvalid), 32'd1);
        chk({nm, "_bresp"}, 32'(bresp), 32'(exp_b));
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        chk({nm, "_bvalid_drop"}, 32'(bvalid), 32'd0);
        chk({nm, "_awready_back"}, 32'(awready), 32'd1);
    endtask

    task automatic do_read(input int v, input int stall_at, input int reset_at);
        rvec_t t;
        int    g;
        t = rv[v];
        araddr = t.addr; arlen = t.len; arsize = t.size; arburst = t.burst;
        arvalid = 1'b1;
        rready  = 1'b1;
        g = 0;
        while (!arready && g < 20) begin @(posedge aclk); #1; g++; end
        chk($sformatf("rd%0d_arready", v), 32'(arready), 32'd1);
        if (!arready) begin arvalid = 1'b0; return; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        for (int i = 0; i <= int'(t.len); i++) begin
            if (i == reset_at) begin
                areset = 1'b1;
                #1;
                chk($sformatf("rd%0d_rst_rvalid", v), 32'(rvalid), 32'd0);
                chk($sformatf("rd%0d_rst_arready", v), 32'(arready), 32'd0);
                chk($sformatf("rd%0d_rst_rdata", v), rdata, 32'd0);
                chk($sformatf("rd%0d_rst_rlast", v), 32'(rlast), 32'd0);
                @(posedge aclk); #1;
                areset = 1'b0;
                rready = 1'b0;
                @(posedge aclk); #1;
                chk($sformatf("rd%0d_rel_arready", v), 32'(arready), 32'd1);
                return;
            end
            if (i == stall_at) begin
                rready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    @(posedge aclk); #1;
                    chk($sformatf("rd%0d_stall%0d_rvalid", v, s), 32'(rvalid), 32'd1);
                    chk($sformatf("rd%0d_stall%0d_rdata", v, s), rdata, t.d[i]);
                    chk($sformatf("rd%0d_stall%0d_rlast", v, s), 32'(rlast), 32'(i == int'(t.len)));
                end
                rready = 1'b1;
            end
            chk($sformatf("rd%0d_b%0d_rvalid", v, i), 32'(rvalid), 32'd1);
            chk($sformatf("rd%0d_b%0d_rdata", v, i), rdata, t.d[i]);
            chk($sformatf("rd%0d_b%0d_rresp", v, i), 32'(rresp), 32'(t.r[i]));
            chk($sformatf("rd%0d_b%0d_rlast", v, i), 32'(rlast), 32'(i == int'(t.len)));
            @(posedge aclk); #1;
        end
        chk($sformatf("rd%0d_done_rvalid", v), 32'(rvalid), 32'd0);
        chk($sformatf("rd%0d_done_arready", v), 32'(arready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

        // Read vectors: addr, len, size, burst, data beats 0..3, resp beats 0..3.
        set_rv(0,  10'h000, 8'd3, 3'd2, 2'd1, 32'h11,  32'h22,  32'h33, 32'h44, 2'd0, 2'd0, 2'd0, 2'd0);
        set_rv(1,  10'h038, 8'd3, 3'd2, 2'd2, 32'hC0,  32'hD0,  32'hA0, 32'hB0, 2'd0, 2'd0, 2'd0, 2'd0);
        set_rv(2,  10'h000, 8'd1, 3'd1, 2'd1, 32'h0,   32'h0,   32'h0,  32'h0,  2'd2, 2'd2, 2'd0, 2'd0);
        set_rv(3,  10'h000, 8'd1, 3'd2, 2'd3, 32'h0,   32'h0,   32'h0,  32'h0,  2'd2, 2'd2, 2'd0, 2'd0);
        set_rv(4,  10'h0FC, 8'd1, 3'd2, 2'd1, 32'hE63, 32'h0,   32'h0,  32'h0,  2'd0, 2'd2, 2'd0, 2'd0);
        set_rv(5,  10'h040, 8'd2, 3'd2, 2'd1, 32'h5A,  32'h5B,  32'h5C, 32'h0,  2'd0, 2'd0, 2'd0, 2'd0);
        set_rv(6,  10'h004, 8'd2, 3'd2, 2'd0, 32'h22,  32'h22,  32'h22, 32'h0,  2'd0, 2'd0, 2'd0, 2'd0);
        set_rv(7,  10'h050, 8'd0, 3'd2, 2'd1, 32'h77,  32'h0,   32'h0,  32'h0,  2'd0, 2'd0, 2'd0, 2'd0);
        set_rv(8,  10'h060, 8'd1, 3'd2, 2'd1, 32'h600, 32'h700, 32'h0,  32'h0,  2'd2, 2'd2, 2'd0, 2'd0);
        set_rv(9,  10'h038, 8'd2, 3'd2, 2'd2, 32'hC0,  32'hD0,  32'h5A, 32'h0,  2'd0, 2'd0, 2'd0, 2'd0);
        set_rv(10, 10'h002, 8'd1, 3'd2, 2'd1, 32'h11,  32'h22,  32'h0,  32'h0,  2'd0, 2'd0, 2'd0, 2'd0);
        set_rv(11, 10'h034, 8'd1, 3'd2, 2'd2, 32'hB0,  32'hA0,  32'h0,  32'h0,  2'd0, 2'd0, 2'd0, 2'd0);
        set_rv(12, 10'h070, 8'd0, 3'd2, 2'd1, 32'h3,   32'h0,   32'h0,  32'h0,  2'd0, 2'd0, 2'd0, 2'd0);
        set_rv(13, 10'h3F8, 8'd1, 3'd2, 2'd1, 32'h0,   32'h0,   32'h0,  32'h0,  2'd2, 2'd2, 2'd0, 2'd0);
        // Vector 8 reads words written with OKAY data; its resp entries are fixed below.
        rv[8].r = {2'd0, 2'd0, 2'd0, 2'd0};

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        chk("rst_rresp",   32'(rresp),   32'd0);
        chk("rst_rlast",   32'(rlast),   32'd0);
        chk("rst_bresp",   32'(bresp),   32'd0);
        areset = 1'b0;
        @(posedge aclk); #1;
        chk("rel_arready", 32'(arready), 32'd1);
        chk("rel_awready", 32'(awready), 32'd1);

        do_write("w_incr0",    10'h000, 8'd3, 3'd2, 2'd1, 32'h11,  32'h11,  3,  2'd0);
        do_write("w_incr12",   10'h030, 8'd3, 3'd2, 2'd1, 32'hA0,  32'h10,  3,  2'd0);
        do_write("w_incr62",   10'h0F8, 8'd1, 3'd2, 2'd1, 32'h62,  32'h1,   1,  2'd0);
        do_write("w_early",    10'h040, 8'd2, 3'd2, 2'd1, 32'h5A,  32'h1,   1,  2'd2);
        do_write("w_word20",   10'h050, 8'd0, 3'd2, 2'd1, 32'h77,  32'h1,   0,  2'd0);
        do_write("w_badsize",  10'h050, 8'd0, 3'd1, 2'd1, 32'h99,  32'h1,   0,  2'd2);
        do_write("w_rsvd",     10'h050, 8'd0, 3'd2, 2'd3, 32'h98,  32'h1,   0,  2'd2);
        do_write("w_oor",      10'h0FC, 8'd1, 3'd2, 2'd1, 32'hE63, 32'h1,   1,  2'd2);
        do_write("w_nolast",   10'h060, 8'd1, 3'd2, 2'd1, 32'h600, 32'h100, -1, 2'd2);
        do_write("w_fixed",    10'h070, 8'd2, 3'd2, 2'd0, 32'h1,   32'h1,   2,  2'd0);

        for (int v = 0; v < NRV; v++)
            do_read(v, -1, -1);

        do_read(0, 1, -1);
        do_read(0, -1, 2);
        do_read(0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
